// File: rtl/fulladder_bist.sv
// rtl/fulladder_bist.sv - built-in self-test engine for a 1-bit full adder
//
// Drives all eight {a,b,cin} combinations into an external full adder, samples
// {cout,sum} after SETTLE cycles per vector, repeats for PASSES sweeps and
// reports the mismatch count plus the first failing vector and its response.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   run request, sampled only while idle
//   a,b,cin    out  stimulus to the adder under test
//   cout,sum   in   response from the adder under test
//   busy       out  high while vectors are applied
//   done       out  one-cycle end-of-run pulse
//   pass       out  last run had zero mismatches (held until next start)
//   err_cnt    out  mismatch count, saturating at 15
//   fail_vec   out  {a,b,cin} of the first mismatch
//   fail_resp  out  {cout,sum} observed at the first mismatch
module fulladder_bist #(
  parameter int SETTLE = 1,
  parameter int PASSES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       cin,
  input  logic       cout,
  input  logic       sum,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] fail_vec,
  output logic [1:0] fail_resp
);

  localparam logic [3:0] LP_SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] LP_PASS_LAST   = 4'(PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [2:0] r_vec;
  logic [3:0] r_settle_cnt;
  logic [3:0] r_pass_cnt;
  logic [3:0] r_err_cnt;
  logic [2:0] r_fail_vec;
  logic [1:0] r_fail_resp;
  logic       r_pass;

  logic       w_sample;
  logic       w_last;
  logic [1:0] w_expect;
  logic       w_mismatch;
  logic [3:0] w_err_next;

  // The response is judged on the last cycle a vector is held.
  assign w_sample   = (r_state == S_DRIVE) && (r_settle_cnt == LP_SETTLE_LAST);
  assign w_last     = w_sample && (r_vec == 3'd7) && (r_pass_cnt == LP_PASS_LAST);

  // Reference {cout,sum}: majority and parity of the three inputs.
  assign w_expect[1] = (r_vec[2] & r_vec[1]) | (r_vec[2] & r_vec[0]) | (r_vec[1] & r_vec[0]);
  assign w_expect[0] = ^r_vec;

  assign w_mismatch = w_sample && ({cout, sum} != w_expect);
  assign w_err_next = (w_mismatch && (r_err_cnt != 4'hf)) ? r_err_cnt + 4'd1 : r_err_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_DRIVE;
      S_DRIVE: if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Counters and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec        <= 3'd0;
      r_settle_cnt <= 4'd0;
      r_pass_cnt   <= 4'd0;
      r_err_cnt    <= 4'd0;
      r_fail_vec   <= 3'd0;
      r_fail_resp  <= 2'd0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vec        <= 3'd0;
            r_settle_cnt <= 4'd0;
            r_pass_cnt   <= 4'd0;
            r_err_cnt    <= 4'd0;
            r_fail_vec   <= 3'd0;
            r_fail_resp  <= 2'd0;
            r_pass       <= 1'b0;
          end
        end
        S_DRIVE: begin
          r_err_cnt <= w_err_next;
          // Only the first mismatch of a run is recorded.
          if (w_mismatch && (r_err_cnt == 4'd0)) begin
            r_fail_vec  <= r_vec;
            r_fail_resp <= {cout, sum};
          end
          if (w_sample) begin
            r_settle_cnt <= 4'd0;
            r_vec        <= r_vec + 3'd1;
            if (r_vec == 3'd7) r_pass_cnt <= r_pass_cnt + 4'd1;
            // Verdict includes the comparison made on this same edge.
            if (w_last) r_pass <= (w_err_next == 4'd0);
          end else begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    a    = 1'b0;
    b    = 1'b0;
    cin  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_DRIVE: begin
        {a, b, cin} = r_vec;
        busy        = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: begin
      end
    endcase
  end

  assign pass      = r_pass;
  assign err_cnt   = r_err_cnt;
  assign fail_vec  = r_fail_vec;
  assign fail_resp = r_fail_resp;

endmodule

// File: tb/tb_fulladder_bist.sv
// tb/tb_fulladder_bist.sv - self-checking bench for fulladder_bist
module tb_fulladder_bist;

  localparam int S_OF [3] = '{1, 1, 3};
  localparam int P_OF [3] = '{1, 3, 1};
  localparam int BUDGET   = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st    [3];
  logic       op_a  [3];
  logic       op_b  [3];
  logic       op_c  [3];
  logic       co    [3];
  logic       su    [3];
  logic       busy  [3];
  logic       done  [3];
  logic       pass  [3];
  logic [3:0] err   [3];
  logic [2:0] fvec  [3];
  logic [1:0] fresp [3];

  int n_cmp;
  int n_bad;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fulladder_bist #(.SETTLE(1), .PASSES(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .a(op_a[0]), .b(op_b[0]), .cin(op_c[0]),
    .cout(co[0]), .sum(su[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_cnt(err[0]), .fail_vec(fvec[0]), .fail_resp(fresp[0]));

  fulladder_bist #(.SETTLE(1), .PASSES(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .a(op_a[1]), .b(op_b[1]), .cin(op_c[1]),
    .cout(co[1]), .sum(su[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_cnt(err[1]), .fail_vec(fvec[1]), .fail_resp(fresp[1]));

  fulladder_bist #(.SETTLE(3), .PASSES(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(st[2]), .a(op_a[2]), .b(op_b[2]), .cin(op_c[2]),
    .cout(co[2]), .sum(su[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_cnt(err[2]), .fail_vec(fvec[2]), .fail_resp(fresp[2]));

  // Arithmetic full adder: {cout,sum} is the two-bit count of ones.
  function automatic logic [1:0] fa(input logic [2:0] v);
    int s;
    s = int'(v[2]) + int'(v[1]) + int'(v[0]);
    return 2'(s);
  endfunction

  // Adders under test: a correct adder with a per-vector XOR fault mask,
  // or a two-register pipelined adder.
  logic [1:0] mask [3][8];
  logic       pipe0;
  logic [1:0] q1   [3];
  logic [1:0] q2   [3];
  logic [1:0] resp [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      q1[i] <= fa({op_a[i], op_b[i], op_c[i]});
      q2[i] <= q1[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      resp[i] = fa({op_a[i], op_b[i], op_c[i]}) ^ mask[i][{op_a[i], op_b[i], op_c[i]}];
    end
    if (pipe0) resp[0] = q2[0];
    resp[2] = q2[2];
  end

  assign {co[0], su[0]} = resp[0];
  assign {co[1], su[1]} = resp[1];
  assign {co[2], su[2]} = resp[2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected results of one run over a masked combinational adder.
  function automatic void model(input int sel, output logic [3:0] e, output logic [2:0] fv,
                                output logic [1:0] fr, output logic p);
    int         cnt;
    logic [2:0] v;
    logic [1:0] r;
    cnt = 0;
    fv  = 3'd0;
    fr  = 2'd0;
    for (int k = 0; k < 8 * P_OF[sel]; k++) begin
      v = 3'(k % 8);
      r = fa(v) ^ mask[sel][v];
      if (r != fa(v)) begin
        if (cnt == 0) begin
          fv = v;
          fr = r;
        end
        cnt++;
      end
    end
    e = (cnt > 15) ? 4'd15 : 4'(cnt);
    p = (cnt == 0);
  endfunction

  // kind: 0 clean, 1 sum stuck at 0, 2 cout inverted, 3 random faults
  task automatic set_mask(input int sel, input int kind);
    logic [1:0] t;
    for (int v = 0; v < 8; v++) begin
      t = fa(3'(v));
      case (kind)
        1:       mask[sel][v] = {1'b0, t[0]};
        2:       mask[sel][v] = 2'b10;
        3:       mask[sel][v] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        default: mask[sel][v] = 2'b00;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int sel, input bit chk_vec);
    int  dlat;
    int  nbusy;
    bit  got;
    int  len;
    got   = 1'b0;
    nbusy = 0;
    dlat  = -1;
    len   = 8 * P_OF[sel] * S_OF[sel];
    st[sel] = 1'b1;
    step();
    st[sel] = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (done[sel]) begin
        got  = 1'b1;
        dlat = i;
        break;
      end
      if (busy[sel]) nbusy++;
      if (chk_vec)
        chk("vec", 8'({op_a[sel], op_b[sel], op_c[sel]}), 8'((i / S_OF[sel]) % 8));
      step();
    end
    chk("done_seen", 8'(got), 8'd1);
    chk("done_lat", 8'(dlat), 8'(len));
    chk("busy_len", 8'(nbusy), 8'(len));
    step();
    chk("done_width", 8'(done[sel]), 8'd0);
    chk("idle_busy", 8'(busy[sel]), 8'd0);
  endtask

  task automatic results(input int sel, input string tag);
    logic [3:0] e;
    logic [2:0] fv;
    logic [1:0] fr;
    logic       p;
    model(sel, e, fv, fr, p);
    chk({tag, ".err"}, 8'(err[sel]), 8'(e));
    chk({tag, ".pass"}, 8'(pass[sel]), 8'(p));
    chk({tag, ".fvec"}, 8'(fvec[sel]), 8'(fv));
    chk({tag, ".fresp"}, 8'(fresp[sel]), 8'(fr));
  endtask

  task automatic chk_zero(input string tag, input int sel);
    chk({tag, ".abc"}, 8'({op_a[sel], op_b[sel], op_c[sel]}), 8'd0);
    chk({tag, ".busy"}, 8'(busy[sel]), 8'd0);
    chk({tag, ".done"}, 8'(done[sel]), 8'd0);
    chk({tag, ".pass"}, 8'(pass[sel]), 8'd0);
    chk({tag, ".err"}, 8'(err[sel]), 8'd0);
    chk({tag, ".fvec"}, 8'(fvec[sel]), 8'd0);
    chk({tag, ".fresp"}, 8'(fresp[sel]), 8'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dq[$];
    int ndone;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    pipe0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      set_mask(i, 0);
    end
    repeat (3) step();
    for (int i = 0; i < 3; i++) chk_zero("reset", i);
    rst = 1'b0;
    step();

    // Clean adder, vector sequence and timing
    set_mask(0, 0);
    run(0, 1'b1);
    results(0, "clean");
    chk("clean.pass1", 8'(pass[0]), 8'd1);

    // Sum stuck at 0
    set_mask(0, 1);
    run(0, 1'b0);
    results(0, "stuck");
    chk("stuck.err4", 8'(err[0]), 8'd4);
    chk("stuck.fvec", 8'(fvec[0]), 8'b001);
    chk("stuck.fresp", 8'(fresp[0]), 8'b00);

    // Inverted cout over three sweeps saturates the counter
    set_mask(1, 2);
    run(1, 1'b0);
    results(1, "invc");
    chk("invc.sat", 8'(err[1]), 8'd15);
    chk("invc.fvec", 8'(fvec[1]), 8'b000);
    chk("invc.fresp", 8'(fresp[1]), 8'b10);

    // Random fault masks
    repeat (6) begin
      set_mask(0, 3);
      run(0, 1'b0);
      results(0, "rnd0");
    end
    repeat (3) begin
      set_mask(1, 3);
      run(1, 1'b1);
      results(1, "rnd1");
    end

    // Reset after four vectors of a faulty run
    set_mask(0, 1);
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    repeat (4) step();
    chk("mid.err_before", 8'(err[0]), 8'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("mid", 0);
    ndone = 0;
    repeat (12) begin
      step();
      if (done[0]) ndone++;
    end
    chk("mid.no_done", 8'(ndone), 8'd0);
    set_mask(0, 0);
    run(0, 1'b0);
    results(0, "after_rst");
    chk("after_rst.pass", 8'(pass[0]), 8'd1);

    // start held high; toggling during a run must not disturb the period
    st[0] = 1'b1;
    repeat (45) begin
      step();
      if (done[0]) dq.push_back(cyc);
      st[0] = (busy[0] || done[0]) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    st[0] = 1'b0;
    repeat (12) step();
    chk("held.pulses", 8'(dq.size() >= 3), 8'd1);
    for (int i = 1; i < dq.size(); i++) chk("held.period", 8'(dq[i] - dq[i-1]), 8'd10);
    chk("held.pass", 8'(pass[0]), 8'd1);

    // Two-register adder: too short a settle time fails, enough time passes
    pipe0 = 1'b1;
    run(0, 1'b0);
    chk("pipe1.pass", 8'(pass[0]), 8'd0);
    chk("pipe1.fvec_nz", 8'(fvec[0] != 3'd0), 8'd1);
    run(2, 1'b1);
    results(2, "pipe3");
    chk("pipe3.pass", 8'(pass[2]), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fulladder_bist.md
# fulladder_bist

Synthesizable built-in self-test engine for a 1-bit full adder. It drives all 8 `{a,b,cin}` input combinations into an external full-adder instance and samples `cout`/`sum` after a programmable settle time. Each response is compared against the arithmetic reference, and the block reports errors and the first failing vector. It sits beside the full-adder cell at the other end of its interface: it replaces the simulation stimulus/monitor with hardware that can run on silicon or FPGA.

## Interface
Parameters:
- `SETTLE`, default 1: cycles each vector is held before its response is sampled; legal range 1..15.
- `PASSES`, default 1: number of complete 8-vector sweeps per run; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; level-sampled only in IDLE.
- `a`  out  1  adder operand A, to the adder under test.
- `b`  out  1  adder operand B, to the adder under test.
- `cin`  out  1  carry-in, to the adder under test.
- `cout`  in  1  carry-out from the adder under test.
- `sum`  in  1  sum from the adder under test.
- `busy`  out  1  high while vectors are being applied.
- `done`  out  1  one-cycle pulse marking the end of a run.
- `pass`  out  1  1 when the completed run had zero mismatches; held until the next start.
- `err_cnt`  out  4  mismatch count; saturates at 15.
- `fail_vec`  out  3  `{a,b,cin}` of the first mismatch.
- `fail_resp`  out  2  `{cout,sum}` observed at the first mismatch.

## Operation
- States:
  - IDLE
  - DRIVE
  - DONE
- Internal counters:
  - `vec` (3 bits), vector index; `{a,b,cin} = vec` while in DRIVE.
  - `settle_cnt` (4 bits), cycles the current vector has been held.
  - `pass_cnt` (4 bits), completed sweeps.
- IDLE:
  - `a`, `b`, `cin` = 0; `busy` = 0.
  - On `start` = 1: go to DRIVE with `vec` = 0, `settle_cnt` = 0, `pass_cnt` = 0.
  - Same edge clears `err_cnt`, `fail_vec`, `fail_resp` and `pass`.
- DRIVE:
  - `busy` = 1.
  - `settle_cnt` increments each cycle.
  - On the cycle where `settle_cnt` = SETTLE-1, the rising edge compares `cout`/`sum` against the expected values and advances the vector.
- Expected values:
  - `sum` = a ^ b ^ cin.
  - `cout` = (a&b) | (a&cin) | (b&cin).
  - A mismatch on either bit counts as one error.
- On a mismatch:
  - `err_cnt` increments, saturating at 15 (a 16th error leaves it at 15).
  - If `err_cnt` was 0 before the increment, `fail_vec` and `fail_resp` are captured. Later mismatches never overwrite them.
- Advance rules:
  - `vec` increments and wraps 7→0; `settle_cnt` resets to 0.
  - When `vec` wraps, `pass_cnt` increments.
  - When `vec` = 7 and `pass_cnt` = PASSES-1, go to DONE instead.
- DONE:
  - `done` = 1, `busy` = 0, `a`/`b`/`cin` = 0.
  - `pass` is set to (final `err_cnt` == 0), using the count that includes the last comparison.
  - Unconditionally return to IDLE on the next edge.
- `start` is ignored in DRIVE and DONE. No queuing.

## Timing
- Reset (`rst` = 1 at an edge) forces:
  - state = IDLE;
  - `a`, `b`, `cin`, `busy`, `done`, `pass` = 0;
  - `err_cnt` = 0, `fail_vec` = 0, `fail_resp` = 0;
  - all internal counters = 0.
- `rst` has priority over `start`.
- Reset mid-DRIVE aborts the run on that edge. No `done` pulse is produced and no results are kept.
- Edge E0 samples `start` = 1 in IDLE.
  - Vector 0 is visible on `a`/`b`/`cin` in the cycle after E0.
  - Vector k (global index k, 0-based across passes) is sampled at edge E0 + SETTLE·(k+1).
- `busy` is high for exactly 8·PASSES·SETTLE cycles.
- `done` is high in the single cycle following the last sample edge.
- IDLE is re-entered one cycle after `done`. With `start` held high, the next run begins at the edge that ends that IDLE cycle.
- Back-to-back run period: 8·PASSES·SETTLE + 2 cycles.
- The adder under test must produce a stable response within SETTLE cycles of a vector change.
  - Combinational DUT: SETTLE = 1 suffices.
  - DUT with N registers of latency: requires SETTLE ≥ N+1.

## Test plan
- Correct combinational adder, SETTLE=1, PASSES=1, 1-cycle `start` pulse:
  - `{a,b,cin}` steps 000..111 over 8 cycles with `busy` = 1.
  - `done` pulses 9 cycles after E0.
  - `pass` = 1, `err_cnt` = 0.
- DUT with `sum` stuck at 0:
  - Mismatches at 001, 010, 100 and 111.
  - `err_cnt` = 4, `fail_vec` = 3'b001, `fail_resp` = 2'b00, `pass` = 0.
- DUT with inverted `cout`, PASSES=3:
  - 24 mismatches occur; `err_cnt` saturates at 15.
  - `fail_vec` = 3'b000, `fail_resp` = 2'b10, `pass` = 0.
- Reset mid-run:
  - Assert `rst` for one cycle after 4 vectors of a faulty-DUT run.
  - Next cycle: all outputs 0, no `done` pulse.
  - A following run on a correct DUT yields `pass` = 1, `err_cnt` = 0.
- `start` held high continuously, correct DUT, SETTLE=1, PASSES=1:
  - Runs repeat with `done` pulses exactly 10 cycles apart.
  - Toggling `start` during DRIVE has no effect.
- Adder model with 2 registered stages:
  - SETTLE=3 gives `pass` = 1.
  - SETTLE=1 gives `pass` = 0 with `fail_vec` ≠ 0 captured.
